sub4bit_serial: RTL

- Bit-serial binary subtractor for the bottling controller. Computes D = A − B − Bin, one bit per clock, LSB first.
- Inverse arithmetic direction of the team's parallel ripple-carry adder. Used where stock or fill counts are decremented by a dispensed quantity.
- A start/busy/done handshake lets the control FSM launch one operation and collect the difference and borrow.

---
 rtl/sub4bit_serial.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sub4bit_serial.sv
// Bit-serial subtractor: D = A - B - Bin, one bit per clock, LSB first.
// A start/busy/done handshake launches one operation at a time; the
// difference, borrow-out and zero flag are held until the next result.
module sub4bit_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             Z
);

  // Counter wide enough to index every bit; at least one bit for WIDTH=1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] res_reg, res_next;
  logic             bw_reg, bw_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] d_reg, d_next;
  logic             bout_reg, bout_next;
  logic             z_reg, z_next;

  // One-bit full-subtractor cell operating on the current LSBs.
  logic d_bit;
  logic bw_bit;
  assign d_bit  = a_reg[0] ^ b_reg[0] ^ bw_reg;
  assign bw_bit = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & bw_reg);

  // Operands shift right to expose the next bit; the result fills from the
  // MSB end so that after WIDTH shifts bit 0 sits at position 0.
  logic [WIDTH-1:0] a_shift;
  logic [WIDTH-1:0] b_shift;
  logic [WIDTH-1:0] res_shift;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
    if (gi < WIDTH - 1) begin : g_mid
      assign a_shift[gi]   = a_reg[gi+1];
      assign b_shift[gi]   = b_reg[gi+1];
      assign res_shift[gi] = res_reg[gi+1];
    end else begin : g_top
      assign a_shift[gi]   = 1'b0;
      assign b_shift[gi]   = 1'b0;
      assign res_shift[gi] = d_bit;
    end
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    res_next   = res_reg;
    bw_next    = bw_reg;
    cnt_next   = cnt_reg;
    d_next     = d_reg;
    bout_next  = bout_reg;
    z_next     = z_reg;
    busy       = 1'b0;
    done       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          a_next     = A;
          b_next     = B;
          bw_next    = Bin;
          res_next   = '0;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        busy     = 1'b1;
        a_next   = a_shift;
        b_next   = b_shift;
        bw_next  = bw_bit;
        res_next = res_shift;
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == LAST_BIT) begin
          // Final bit: commit the full result together with its flags.
          d_next     = res_shift;
          bout_next  = bw_bit;
          z_next     = (res_shift == '0);
          cnt_next   = '0;
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      bw_reg    <= 1'b0;
      cnt_reg   <= '0;
      d_reg     <= '0;
      bout_reg  <= 1'b0;
      z_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      res_reg   <= res_next;
      bw_reg    <= bw_next;
      cnt_reg   <= cnt_next;
      d_reg     <= d_next;
      bout_reg  <= bout_next;
      z_reg     <= z_next;
    end
  end

  assign D    = d_reg;
  assign Bout = bout_reg;
  assign Z    = z_reg;

endmodule
